// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding,
// reset-cause codes and a counter-width helper.
package reset_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_HOLD      = 2'd1,
        ST_RUN       = 2'd2,
        ST_ARMED     = 2'd3
    } state_t;

    localparam logic [1:0] CAUSE_POR    = 2'b00;
    localparam logic [1:0] CAUSE_BUTTON = 2'b01;
    localparam logic [1:0] CAUSE_PLL    = 2'b10;

    // Width needed to count 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        if ($clog2(n) < 1) return 1;
        return $clog2(n);
    endfunction

endpackage

// File: rtl/sync_debounce.sv
// Synchronizer followed by a debounce counter. The accepted level only
// moves after the synced input has disagreed with it for DEBOUNCE_CYCLES
// consecutive cycles. o_rise / o_fall pulse combinationally in the cycle
// whose edge commits the new level, so a consumer can act on that edge.
module sync_debounce
    import reset_sequencer_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_level;
    logic [CW-1:0]          r_cnt;
    logic                   w_synced;
    logic                   w_differ;
    logic                   w_accept;

    assign w_synced = r_sync[SYNC_STAGES-1];
    assign w_differ = (w_synced != r_level);
    assign w_accept = w_differ && (r_cnt == CNT_LAST);

    assign o_level = r_level;
    assign o_rise  = w_accept && w_synced;
    assign o_fall  = w_accept && !w_synced;

    // Synchronizer shift chain plus persistence counter for the level.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= '0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            if (w_accept) begin
                r_level <= w_synced;
                r_cnt   <= '0;
            end else if (w_differ) begin
                r_cnt <= r_cnt + CW'(1);
            end else begin
                r_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// System reset generator. Waits for a stable PLL lock, holds reset for a
// minimum width, then runs. A debounced button press+release re-enters
// HOLD; loss of lock at any point after WAIT_LOCK restarts from WAIT_LOCK.
// sys_reset is registered from the next state so it moves on the same
// edge as the state register.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 256,
    parameter int HOLD_CYCLES        = 64,
    parameter int DEBOUNCE_CYCLES    = 65536
) (
    input  logic       io_mainClk,
    input  logic       reset,
    input  logic       pll_locked,
    input  logic       greset_in,
    output logic       sys_reset,
    output logic [1:0] reset_cause,
    output logic [7:0] reset_count,
    output logic       button_level
);

    localparam int LW = cnt_width(LOCK_STABLE_CYCLES);
    localparam int HW = cnt_width(HOLD_CYCLES);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_lock_sync;
    state_t                 r_state;
    logic [LW-1:0]          r_lock_cnt;
    logic [HW-1:0]          r_hold_cnt;
    logic                   r_sys_reset;
    logic [1:0]             r_cause;
    logic [7:0]             r_count;

    state_t                 w_next_state;
    logic                   w_lock;
    logic                   w_pll_loss;
    logic                   w_btn_reset;
    logic                   w_btn_level;
    logic                   w_btn_rise;
    logic                   w_btn_fall;

    assign w_lock = r_lock_sync[SYNC_STAGES-1];

    sync_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk    (io_mainClk),
        .rst    (reset),
        .i_async(greset_in),
        .o_level(w_btn_level),
        .o_rise (w_btn_rise),
        .o_fall (w_btn_fall)
    );

    // PLL lock flag synchronizer; no debounce, any synced low is a loss.
    always_ff @(posedge io_mainClk) begin
        if (reset) begin
            r_lock_sync <= '0;
        end else begin
            r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], pll_locked};
        end
    end

    // Next-state logic; lock loss is checked before any button event.
    always_comb begin
        w_next_state = r_state;
        w_pll_loss   = 1'b0;
        w_btn_reset  = 1'b0;
        case (r_state)
            ST_WAIT_LOCK: begin
                if (w_lock && (r_lock_cnt == LOCK_LAST)) w_next_state = ST_HOLD;
            end
            ST_HOLD: begin
                if (!w_lock) begin
                    w_next_state = ST_WAIT_LOCK;
                    w_pll_loss   = 1'b1;
                end else if (r_hold_cnt == HOLD_LAST) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!w_lock) begin
                    w_next_state = ST_WAIT_LOCK;
                    w_pll_loss   = 1'b1;
                end else if (w_btn_rise) begin
                    w_next_state = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (!w_lock) begin
                    w_next_state = ST_WAIT_LOCK;
                    w_pll_loss   = 1'b1;
                end else if (w_btn_fall) begin
                    w_next_state = ST_HOLD;
                    w_btn_reset  = 1'b1;
                end
            end
            default: w_next_state = ST_WAIT_LOCK;
        endcase
    end

    // State register.
    always_ff @(posedge io_mainClk) begin
        if (reset) begin
            r_state <= ST_WAIT_LOCK;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Dwell counters: each counts only while staying in its own state, so
    // it is zero on every entry.
    always_ff @(posedge io_mainClk) begin
        if (reset) begin
            r_lock_cnt <= '0;
            r_hold_cnt <= '0;
        end else begin
            if ((r_state == ST_WAIT_LOCK) && (w_next_state == ST_WAIT_LOCK) && w_lock)
                r_lock_cnt <= r_lock_cnt + LW'(1);
            else
                r_lock_cnt <= '0;
            if ((r_state == ST_HOLD) && (w_next_state == ST_HOLD))
                r_hold_cnt <= r_hold_cnt + HW'(1);
            else
                r_hold_cnt <= '0;
        end
    end

    // Output registers: reset line, last cause and saturating button count.
    always_ff @(posedge io_mainClk) begin
        if (reset) begin
            r_sys_reset <= 1'b1;
            r_cause     <= CAUSE_POR;
            r_count     <= 8'd0;
        end else begin
            r_sys_reset <= !((w_next_state == ST_RUN) || (w_next_state == ST_ARMED));
            if (w_pll_loss) begin
                r_cause <= CAUSE_PLL;
            end else if (w_btn_reset) begin
                r_cause <= CAUSE_BUTTON;
                if (r_count != 8'hFF) r_count <= r_count + 8'd1;
            end
        end
    end

    assign sys_reset    = r_sys_reset;
    assign reset_cause  = r_cause;
    assign reset_count  = r_count;
    assign button_level = w_btn_level;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer with SYNC=2, LOCK=4, HOLD=8, DEBOUNCE=4.
module tb_reset_sequencer;
    import reset_sequencer_pkg::*;

    logic       clk;
    logic       reset;
    logic       pll_locked;
    logic       greset_in;
    logic       sys_reset;
    logic [1:0] reset_cause;
    logic [7:0] reset_count;
    logic       button_level;

    int n_checks;
    int n_errors;

    typedef struct {
        logic       rst;
        logic       pll;
        logic       btn;
        logic       e_rst;
        logic [1:0] e_cause;
        logic [7:0] e_cnt;
        logic       e_lvl;
    } vec_t;

    vec_t vecs[$];

    reset_sequencer #(
        .SYNC_STAGES       (2),
        .LOCK_STABLE_CYCLES(4),
        .HOLD_CYCLES       (8),
        .DEBOUNCE_CYCLES   (4)
    ) dut (
        .io_mainClk  (clk),
        .reset       (reset),
        .pll_locked  (pll_locked),
        .greset_in   (greset_in),
        .sys_reset   (sys_reset),
        .reset_cause (reset_cause),
        .reset_count (reset_count),
        .button_level(button_level)
    );

    // Clock: 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Advance n active edges, then settle 1 ns past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input logic rst, input logic pll, input logic btn, input logic e_rst,
                           input logic [1:0] e_cause, input logic [7:0] e_cnt, input logic e_lvl);
        vec_t v;
        v.rst = rst; v.pll = pll; v.btn = btn;
        v.e_rst = e_rst; v.e_cause = e_cause; v.e_cnt = e_cnt; v.e_lvl = e_lvl;
        vecs.push_back(v);
    endtask

    task automatic check_outputs(input string tag, input logic e_rst, input logic [1:0] e_cause,
                                 input logic [7:0] e_cnt, input logic e_lvl);
        chk({tag, ".sys_reset"}, 32'(sys_reset), 32'(e_rst));
        chk({tag, ".reset_cause"}, 32'(reset_cause), 32'(e_cause));
        chk({tag, ".reset_count"}, 32'(reset_count), 32'(e_cnt));
        chk({tag, ".button_level"}, 32'(button_level), 32'(e_lvl));
    endtask

    // Step until sys_reset drops, with a cycle budget.
    task automatic wait_run(input string name, input int budget);
        int n;
        n = 0;
        while (sys_reset !== 1'b0 && n < budget) begin
            step(1);
            n++;
        end
        chk(name, 32'(sys_reset), 32'd0);
    endtask

    // One full press/release: 7 cycles pressed, 7 released, then back to RUN.
    task automatic button_cycle();
        greset_in = 1'b1;
        step(7);
        greset_in = 1'b0;
        step(7);
        wait_run("btn_cycle_run", 30);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        reset      = 1'b1;
        pll_locked = 1'b1;
        greset_in  = 1'b0;

        // Reset, release with lock high, then a 3-cycle glitch in RUN.
        add_vec(1, 1, 0, 1, CAUSE_POR, 0, 0);
        add_vec(1, 1, 0, 1, CAUSE_POR, 0, 0);
        for (int k = 1; k <= 14; k++) add_vec(0, 1, 0, (k <= 13), CAUSE_POR, 0, 0);
        for (int k = 0; k < 3; k++) add_vec(0, 1, 1, 0, CAUSE_POR, 0, 0);
        for (int k = 0; k < 6; k++) add_vec(0, 1, 0, 0, CAUSE_POR, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            reset      = vecs[i].rst;
            pll_locked = vecs[i].pll;
            greset_in  = vecs[i].btn;
            step(1);
            check_outputs($sformatf("vec%0d", i), vecs[i].e_rst, vecs[i].e_cause,
                          vecs[i].e_cnt, vecs[i].e_lvl);
        end

        // Button pressed 10 cycles: accepted at +6, release accepted at +16,
        // HOLD for 8 cycles, RUN again at +24.
        greset_in = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            if (k == 11) greset_in = 1'b0;
            step(1);
            check_outputs($sformatf("btn%0d", k), (k >= 16 && k <= 23),
                          (k >= 16) ? CAUSE_BUTTON : CAUSE_POR,
                          (k >= 16) ? 8'd1 : 8'd0, (k >= 6 && k <= 15));
        end

        // One-cycle lock drop in RUN: reset at +3, relock 4, hold 8, RUN at +15.
        for (int k = 1; k <= 18; k++) begin
            if (k == 1) pll_locked = 1'b0;
            if (k == 2) pll_locked = 1'b1;
            step(1);
            check_outputs($sformatf("pll%0d", k), (k >= 3 && k <= 14),
                          (k >= 3) ? CAUSE_PLL : CAUSE_BUTTON, 8'd1, 1'b0);
        end

        // Lock pattern 1,1,1,0 never reaches four stable cycles.
        pll_locked = 1'b0;
        step(4);
        chk("lockdrop.cause", 32'(reset_cause), 32'(CAUSE_PLL));
        for (int k = 0; k < 20; k++) begin
            pll_locked = ((k % 4) != 3);
            step(1);
            chk($sformatf("toggle%0d.sys_reset", k), 32'(sys_reset), 32'd1);
            chk($sformatf("toggle%0d.state", k), 32'(dut.r_state), 32'(ST_WAIT_LOCK));
        end
        pll_locked = 1'b1;
        wait_run("relock_run", 40);

        // In ARMED, release and lock loss land on the same edge.
        greset_in = 1'b1;
        step(7);
        chk("armed.level", 32'(button_level), 32'd1);
        chk("armed.state", 32'(dut.r_state), 32'(ST_ARMED));
        greset_in = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            if (k == 4) pll_locked = 1'b0;
            step(1);
            if (k < 6) begin
                chk($sformatf("same%0d.sys_reset", k), 32'(sys_reset), 32'd0);
            end else begin
                check_outputs("same6", 1'b1, CAUSE_PLL, 8'd1, 1'b0);
                chk("same6.state", 32'(dut.r_state), 32'(ST_WAIT_LOCK));
            end
        end
        pll_locked = 1'b1;
        wait_run("same_relock_run", 40);

        // 256 button cycles: count climbs from 1 and saturates at 255.
        for (int i = 0; i < 256; i++) begin
            button_cycle();
            chk($sformatf("sat%0d.count", i), 32'(reset_count),
                (i + 2 > 255) ? 32'd255 : 32'(i + 2));
        end
        chk("sat.cause", 32'(reset_cause), 32'(CAUSE_BUTTON));

        // Reset asserted mid-operation, with the button held.
        greset_in = 1'b1;
        step(7);
        reset = 1'b1;
        step(1);
        check_outputs("midreset", 1'b1, CAUSE_POR, 8'd0, 1'b0);
        chk("midreset.state", 32'(dut.r_state), 32'(ST_WAIT_LOCK));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
